// File: rtl/updown_counter_169.sv
// Presettable binary up/down counter in the style of the 74xx169.
// The counter is built from cascaded 4-bit stages with a ripple enable.
// Each stage steps only when every stage below it sits at its terminal
// nibble for the current direction, so the cascade behaves exactly like a
// plain W-bit add/subtract.

// One 4-bit stage of the cascade.
module updown_counter_169_stage (
  input  logic       clk,
  input  logic       mrn,
  input  logic       step,
  input  logic       ud,
  input  logic       pen,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       term
);

  logic [3:0] q_r;

  // A nibble is terminal at F when counting up and at 0 when counting down.
  function automatic logic nibble_term(input logic [3:0] value, input logic up);
    logic result;
    if (up) begin
      result = (value == 4'hF);
    end else begin
      result = (value == 4'h0);
    end
    return result;
  endfunction

  // Nibble register: a load wins over a step; step already folds in the enables and the ripple.
  always_ff @(posedge clk or negedge mrn) begin
    if (!mrn) begin
      q_r <= 4'h0;
    end else if (!pen) begin
      q_r <= d;
    end else if (step) begin
      if (ud) begin
        q_r <= q_r + 4'h1;
      end else begin
        q_r <= q_r - 4'h1;
      end
    end else begin
      q_r <= q_r;
    end
  end

  assign q    = q_r;
  assign term = nibble_term(q_r, ud);

endmodule

// Top level: chains STAGES nibble stages and forms the direction-aware tc.
module updown_counter_169 #(
  parameter int STAGES = 1
) (
  input  logic                  clk,
  input  logic                  mrn,
  input  logic                  cep,
  input  logic                  cet,
  input  logic                  ud,
  input  logic                  pen,
  input  logic [4*STAGES-1:0]   d,
  output logic [4*STAGES-1:0]   q,
  output logic                  tc
);

  // ripple_s[i] is the step enable for stage i; ripple_s[STAGES] means all stages are terminal.
  logic [STAGES:0]   ripple_s;
  logic [STAGES-1:0] term_s;
  logic [STAGES:0]   all_term_s;

  assign ripple_s[0]   = cep & cet;
  assign all_term_s[0] = 1'b1;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    updown_counter_169_stage u_stage (
      .clk  (clk),
      .mrn  (mrn),
      .step (ripple_s[i]),
      .ud   (ud),
      .pen  (pen),
      .d    (d[4*i+3:4*i]),
      .q    (q[4*i+3:4*i]),
      .term (term_s[i])
    );
    assign ripple_s[i+1]   = ripple_s[i] & term_s[i];
    assign all_term_s[i+1] = all_term_s[i] & term_s[i];
  end

  // tc is combinational and independent of cep and pen, so it is built from cet and the stage terms only.
  assign tc = cet & all_term_s[STAGES];

endmodule

// File: tb/tb_updown_counter_169.sv
// Bench for updown_counter_169: a 1-stage and a 2-stage instance share stimulus
// and are compared against an arithmetic reference model of the counter.
module tb_updown_counter_169;

  logic       clk;
  logic       mrn;
  logic       cep;
  logic       cet;
  logic       ud;
  logic       pen;
  logic [7:0] d;
  logic [3:0] q1;
  logic [7:0] q2;
  logic       tc1;
  logic       tc2;

  int checks   = 0;
  int failures = 0;
  int m1       = 0;
  int m2       = 0;

  updown_counter_169 #(.STAGES(1)) dut1 (
    .clk (clk), .mrn (mrn), .cep (cep), .cet (cet), .ud (ud), .pen (pen),
    .d   (d[3:0]), .q (q1), .tc (tc1)
  );

  updown_counter_169 #(.STAGES(2)) dut2 (
    .clk (clk), .mrn (mrn), .cep (cep), .cet (cet), .ud (ud), .pen (pen),
    .d   (d), .q (q2), .tc (tc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference next value of a counter of the given modulus.
  function automatic int model_next(input int m, input int modulus);
    int r;
    if (!mrn)              r = 0;
    else if (!pen)         r = int'(d) % modulus;
    else if (cep && cet)   r = ud ? (m + 1) % modulus : (m + modulus - 1) % modulus;
    else                   r = m;
    return r;
  endfunction

  function automatic logic model_tc(input int m, input int modulus);
    return cet && ((ud && m == modulus - 1) || (!ud && m == 0));
  endfunction

  task automatic check_model(input string tag);
    check_value({tag, "_q1"},  {28'd0, q1},  m1);
    check_value({tag, "_tc1"}, {31'd0, tc1}, {31'd0, model_tc(m1, 16)});
    check_value({tag, "_q2"},  {24'd0, q2},  m2);
    check_value({tag, "_tc2"}, {31'd0, tc2}, {31'd0, model_tc(m2, 256)});
  endtask

  // One rising edge: update the model with the inputs present at the edge, then check.
  task automatic tick(input string tag);
    @(posedge clk);
    m1 = model_next(m1, 16);
    m2 = model_next(m2, 256);
    #1;
    check_model(tag);
  endtask

  initial begin
    // 1. reset and hold
    mrn = 1'b0; d = 8'h05; pen = 1'b1; ud = 1'b1; cep = 1'b1; cet = 1'b1;
    #12;
    check_value("reset_q1", {28'd0, q1}, 32'h0);
    check_value("reset_q2", {24'd0, q2}, 32'h0);
    check_value("reset_tc1_up", {31'd0, tc1}, 32'h0);
    mrn = 1'b1;
    #1;
    check_value("release_q1", {28'd0, q1}, 32'h0);
    tick("rst_e1");
    tick("rst_e2");
    check_value("count2_q1", {28'd0, q1}, 32'h2);
    #2;
    mrn = 1'b0; m1 = 0; m2 = 0;
    #1;
    check_value("async_rst_q1", {28'd0, q1}, 32'h0);
    check_value("async_rst_q2", {24'd0, q2}, 32'h0);
    tick("rst_held");
    mrn = 1'b1; ud = 1'b0;
    #1;
    check_value("reset_tc1_down", {31'd0, tc1}, 32'h1);

    // 2. down count and wrap
    pen = 1'b0; d = 8'h02; tick("load2");
    pen = 1'b1; ud = 1'b0;
    tick("dn1"); tick("dn2");
    check_value("dn_zero_q1", {28'd0, q1}, 32'h0);
    check_value("dn_zero_tc1", {31'd0, tc1}, 32'h1);
    tick("dn_wrap");
    check_value("wrap_q1", {28'd0, q1}, 32'hF);
    check_value("wrap_tc1", {31'd0, tc1}, 32'h0);
    check_value("wrap_q2", {24'd0, q2}, 32'hFF);
    ud = 1'b1; #1;
    check_value("ud_tc1", {31'd0, tc1}, 32'h1);
    check_value("ud_tc2", {31'd0, tc2}, 32'h1);

    // 3. enables
    pen = 1'b0; d = 8'h09; tick("load9");
    pen = 1'b1; cep = 1'b0;
    for (int i = 0; i < 3; i++) tick("cep0");
    check_value("cep0_q1", {28'd0, q1}, 32'h9);
    cep = 1'b1; cet = 1'b0;
    for (int i = 0; i < 3; i++) tick("cet0");
    check_value("cet0_q1", {28'd0, q1}, 32'h9);
    pen = 1'b0; d = 8'hFF; tick("loadF");
    pen = 1'b1; #1;
    check_value("cet0_tc1", {31'd0, tc1}, 32'h0);
    cet = 1'b1; #1;
    check_value("cet1_tc1", {31'd0, tc1}, 32'h1);

    // 4. load priority over wrap
    pen = 1'b0; d = 8'h03; tick("load_noWrap");
    check_value("nowrap_q1", {28'd0, q1}, 32'h3);
    for (int i = 0; i < 2; i++) tick("load_hold");
    check_value("loadhold_q1", {28'd0, q1}, 32'h3);

    // 5. mid-count reversal
    d = 8'h07; tick("load7");
    pen = 1'b1; ud = 1'b1;
    tick("up8"); tick("up9");
    check_value("rev_up_q1", {28'd0, q1}, 32'h9);
    ud = 1'b0;
    tick("dn8"); tick("dn7"); tick("dn6");
    check_value("rev_dn_q1", {28'd0, q1}, 32'h6);

    // 6. cascade
    pen = 1'b0; d = 8'h10; tick("ld10");
    pen = 1'b1; ud = 1'b0; tick("c_dn");
    check_value("casc_0F", {24'd0, q2}, 32'h0F);
    ud = 1'b1; tick("c_up");
    check_value("casc_10", {24'd0, q2}, 32'h10);
    pen = 1'b0; d = 8'h00; tick("ld00");
    pen = 1'b1; ud = 1'b0; tick("c_wrapdn");
    check_value("casc_FF", {24'd0, q2}, 32'hFF);
    check_value("casc_FF_tc", {31'd0, tc2}, 32'h0);
    ud = 1'b1; tick("c_wrapup");
    check_value("casc_00", {24'd0, q2}, 32'h00);
    check_value("casc_00_tc_up", {31'd0, tc2}, 32'h0);
    ud = 1'b0; #1;
    check_value("casc_00_tc_dn", {31'd0, tc2}, 32'h1);

    // randomized run
    for (int i = 0; i < 600; i++) begin
      mrn = ($urandom_range(0, 31) != 0);
      pen = ($urandom_range(0, 7) != 0);
      cep = ($urandom_range(0, 5) != 0);
      cet = ($urandom_range(0, 5) != 0);
      ud  = ($urandom_range(0, 3) != 0) ? ud : ~ud;
      d   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 1) ? 8'hFF : 8'h00);
      #1;
      if (!mrn) begin
        m1 = 0;
        m2 = 0;
      end
      check_model("rnd_pre");
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
